// File: rtl/pv2000_clk_ctrl.sv
// PV-2000 clock/reset controller: turns PLL lock and the user reset into a held
// core reset, and derives the VDP, CPU, CPU half-phase and PSG clock enables.
module pv2000_clk_ctrl #(
  parameter int DIV_VDP     = 4,
  parameter int DIV_CPU     = 12,
  parameter int RST_HOLD    = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk_sys,
  input  logic i_reset,
  input  logic i_pll_locked,
  input  logic i_pause,
  output logic o_core_reset,
  output logic o_ce_vdp,
  output logic o_ce_cpu,
  output logic o_ce_cpu_n,
  output logic o_ce_psg,
  output logic o_ready
);

  localparam int VW = $clog2(DIV_VDP);
  localparam int CW = $clog2(DIV_CPU);
  localparam int HW = $clog2(RST_HOLD + 1);

  localparam logic [VW-1:0] VDP_LAST = VW'(DIV_VDP - 1);
  localparam logic [CW-1:0] CPU_LAST = CW'(DIV_CPU - 1);
  localparam logic [CW-1:0] CPU_HALF = CW'(DIV_CPU / 2 - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [VW-1:0]          r_vdp_cnt;
  logic [CW-1:0]          r_cpu_cnt;
  logic [HW-1:0]          r_hold_cnt;
  logic                   r_pause_lat;
  logic                   w_lock_s;
  logic                   w_hold;
  logic                   w_holding;

  // The lock flag is asynchronous; the sync chain also clears on reset so a
  // reset always re-runs the lock qualification.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pll_locked};
    end
  end

  assign w_lock_s  = r_sync[SYNC_STAGES-1];
  assign w_hold    = i_reset | ~w_lock_s;
  assign w_holding = (r_hold_cnt < HOLD_MAX);

  always_ff @(posedge i_clk_sys) begin
    if (w_hold) begin
      r_vdp_cnt    <= '0;
      r_cpu_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_pause_lat  <= 1'b0;
      o_ce_vdp     <= 1'b0;
      o_ce_cpu     <= 1'b0;
      o_ce_cpu_n   <= 1'b0;
      o_ce_psg     <= 1'b0;
      o_core_reset <= 1'b1;
      o_ready      <= 1'b0;
    end else begin
      r_vdp_cnt <= (r_vdp_cnt == VDP_LAST) ? '0 : r_vdp_cnt + 1'b1;
      r_cpu_cnt <= (r_cpu_cnt == CPU_LAST) ? '0 : r_cpu_cnt + 1'b1;
      if (w_holding) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
      o_core_reset <= w_holding;
      o_ready      <= ~w_holding;

      // Strobes fire on the last count of each period, so the first pulse
      // lands exactly DIV cycles after release.
      o_ce_vdp   <= (r_vdp_cnt == VDP_LAST);
      o_ce_psg   <= (r_cpu_cnt == CPU_LAST);
      o_ce_cpu   <= (r_cpu_cnt == CPU_LAST) & ~r_pause_lat;
      o_ce_cpu_n <= (r_cpu_cnt == CPU_HALF) & ~r_pause_lat;

      // Pause only changes on a period boundary; the strobe above still
      // sees the previous value.
      if (r_cpu_cnt == CPU_LAST) begin
        r_pause_lat <= i_pause;
      end
    end
  end

endmodule

// File: tb/tb_pv2000_clk_ctrl.sv
// Directed bench for pv2000_clk_ctrl: table-driven release/pause sequence plus
// hand-written lock-loss, reset-glitch and steady-state sequences.
module tb_pv2000_clk_ctrl;

  localparam int DIV_VDP     = 4;
  localparam int DIV_CPU     = 12;
  localparam int RST_HOLD    = 16;
  localparam int SYNC_STAGES = 2;
  localparam int NROWS       = 75;
  localparam logic [5:0] RESET_VAL = 6'b100000;

  logic clk;
  logic i_reset;
  logic i_pll_locked;
  logic i_pause;
  logic o_core_reset;
  logic o_ce_vdp;
  logic o_ce_cpu;
  logic o_ce_cpu_n;
  logic o_ce_psg;
  logic o_ready;
  logic [5:0] w_outs;

  // Bit order: {core_reset, ready, ce_vdp, ce_cpu, ce_cpu_n, ce_psg}
  typedef struct {
    logic       pause;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [1:NROWS];
  int   n_checks = 0;
  int   n_errors = 0;

  pv2000_clk_ctrl #(
    .DIV_VDP    (DIV_VDP),
    .DIV_CPU    (DIV_CPU),
    .RST_HOLD   (RST_HOLD),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .i_clk_sys   (clk),
    .i_reset     (i_reset),
    .i_pll_locked(i_pll_locked),
    .i_pause     (i_pause),
    .o_core_reset(o_core_reset),
    .o_ce_vdp    (o_ce_vdp),
    .o_ce_cpu    (o_ce_cpu),
    .o_ce_cpu_n  (o_ce_cpu_n),
    .o_ce_psg    (o_ce_psg),
    .o_ready     (o_ready)
  );

  assign w_outs = {o_core_reset, o_ready, o_ce_vdp, o_ce_cpu, o_ce_cpu_n, o_ce_psg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string name, input int idx, input logic [5:0] got,
                           input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %b required %b", name, idx, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Reset for nrst edges, then the sync chain needs SYNC_STAGES more edges.
  task automatic start_up(input int nrst, input string tag);
    i_reset = 1'b1;
    for (int k = 0; k < nrst; k++) begin
      step();
      check_vec({tag, "_rst"}, k, w_outs, RESET_VAL);
    end
    i_reset = 1'b0;
    for (int k = 0; k < SYNC_STAGES; k++) begin
      step();
      check_vec({tag, "_sync"}, k, w_outs, RESET_VAL);
    end
  endtask

  task automatic run_rows(input int first, input int last, input string tag);
    for (int c = first; c <= last; c++) begin
      i_pause = tbl[c].pause;
      step();
      $display("%s cycle %0d pause=%b outs=%b exp=%b", tag, c, tbl[c].pause, w_outs,
               tbl[c].exp);
      check_vec(tag, c, w_outs, tbl[c].exp);
    end
  endtask

  initial begin
    int psg_c  [6] = '{12, 24, 36, 48, 60, 72};
    int cpu_c  [4] = '{12, 24, 36, 72};
    int cpun_c [4] = '{6, 18, 30, 66};
    int cnt_vdp, cnt_cpu, cnt_cpun, cnt_psg, bad_align, bad_overlap;
    int found;

    // Pause high for cycles 27..53: latched at 36 and 48, cleared at 60.
    for (int c = 1; c <= NROWS; c++) begin
      tbl[c].pause = (c >= 27 && c < 54);
      tbl[c].exp   = {(c <= RST_HOLD), (c > RST_HOLD), (c % DIV_VDP == 0), 3'b000};
    end
    foreach (psg_c[i])  tbl[psg_c[i]].exp[0]  = 1'b1;
    foreach (cpu_c[i])  tbl[cpu_c[i]].exp[2]  = 1'b1;
    foreach (cpun_c[i]) tbl[cpun_c[i]].exp[1] = 1'b1;

    i_reset      = 1'b1;
    i_pll_locked = 1'b1;
    i_pause      = 1'b0;

    start_up(3, "startup");
    run_rows(1, NROWS, "release");

    // Steady state, 1200 cycles, no pause.
    i_pause = 1'b0;
    cnt_vdp = 0; cnt_cpu = 0; cnt_cpun = 0; cnt_psg = 0;
    bad_align = 0; bad_overlap = 0;
    for (int k = 0; k < 1200; k++) begin
      step();
      cnt_vdp  += int'(o_ce_vdp);
      cnt_cpu  += int'(o_ce_cpu);
      cnt_cpun += int'(o_ce_cpu_n);
      cnt_psg  += int'(o_ce_psg);
      if (o_ce_cpu && !o_ce_vdp) bad_align++;
      if (o_ce_cpu && o_ce_cpu_n) bad_overlap++;
    end
    $display("steady vdp=%0d cpu=%0d cpu_n=%0d psg=%0d", cnt_vdp, cnt_cpu, cnt_cpun, cnt_psg);
    check_int("steady_ce_vdp", cnt_vdp, 300);
    check_int("steady_ce_cpu", cnt_cpu, 100);
    check_int("steady_ce_cpu_n", cnt_cpun, 100);
    check_int("steady_ce_psg", cnt_psg, 100);
    check_int("steady_cpu_vdp_align", bad_align, 0);
    check_int("steady_cpu_cpun_overlap", bad_overlap, 0);

    // One-cycle lock dropout, changed away from the clock edge.
    i_pll_locked = 1'b0;
    found = 0;
    for (int k = 0; k <= SYNC_STAGES && found == 0; k++) begin
      step();
      i_pll_locked = 1'b1;
      if (o_core_reset) found = 1;
    end
    $display("lock loss: core_reset seen=%0d outs=%b", found, w_outs);
    check_int("lockloss_detect", found, 1);
    check_vec("lockloss_hold", 0, w_outs, RESET_VAL);
    run_rows(1, 26, "relock");

    // Lock absent, reset toggling: nothing may leave the reset state.
    i_pll_locked = 1'b0;
    i_reset      = 1'b1;
    step();
    check_vec("nolock_enter", 0, w_outs, RESET_VAL);
    for (int k = 0; k < 200; k++) begin
      i_reset = 1'($urandom_range(0, 1));
      step();
      check_vec("nolock", k, w_outs, RESET_VAL);
    end

    // One-cycle reset exactly on the cycle ce_cpu would fire (cycle 24).
    i_pll_locked = 1'b1;
    start_up(1, "relock2");
    run_rows(1, 23, "pre_glitch");
    start_up(1, "glitch");
    run_rows(1, 20, "post_glitch");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
